ahb_slave_mem: RTL

//  AHB-Lite slave with word-organised on-chip SRAM. This is the DUT that the AHB

---
 rtl/ahb_slave_mem.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB-Lite slave in front of a word-organised on-chip SRAM.
//
// Serves byte, half and word reads and writes. A transfer whose size, alignment
// or address is illegal gets the two-cycle ERROR response and has no side
// effect. A read accepted on the same edge that commits a write to the same word
// is given the merged new word through a forwarding path.
//
// Optional feature: define AHB_SLV_WAIT_STATE_EN to insert WAIT_CYCLES wait
// states into every non-error data phase. In the default build there are no wait
// states and no wait counter.
//
// Ports
//   HCLK       in   bus clock, rising edge
//   HRESETn    in   asynchronous active-low reset
//   HSEL       in   slave select
//   HADDR      in   byte address (address phase)
//   HTRANS     in   IDLE/BUSY/NONSEQ/SEQ; only bit 1 matters here
//   HWRITE     in   1 = write
//   HSIZE      in   000 byte, 001 half, 010 word
//   HBURST     in   informational only; every beat carries its own HADDR
//   HWDATA     in   write data (data phase)
//   HREADY     in   bus-level ready
//   HRDATA     out  read data, registered
//   HREADYOUT  out  slave ready, registered
//   HRESP      out  0 OKAY, 1 ERROR, registered
module ahb_slave_mem #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,   // only 32 is supported
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP
);
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_DEPTH * 4);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t                r_state;
    logic [IDX_W+1:0]      r_addr;
    logic                  r_write;
    logic [2:0]            r_size;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_readyout;
    logic                  r_resp;
    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic                  w_accept;
    logic                  w_err;
    logic                  w_commit;
    logic                  w_waiting;
    logic [IDX_W-1:0]      w_idx;
    logic [IDX_W-1:0]      w_wr_idx;
    logic [3:0]            w_be;
    logic [DATA_WIDTH-1:0] w_wmerge;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic                  w_unused;

    assign w_unused = ^{HBURST, HTRANS[0]};

    assign w_accept = HSEL && HREADY && HTRANS[1];
    assign w_err    = (HSIZE > 3'b010)
                   || (HSIZE == 3'b001 && HADDR[0])
                   || (HSIZE == 3'b010 && HADDR[1:0] != 2'b00)
                   || (HADDR >= MEM_BYTES);
    assign w_idx    = HADDR[IDX_W+1:2];
    assign w_wr_idx = r_addr[IDX_W+1:2];

    // A write lands on the edge that ends its data phase (HREADYOUT high).
    assign w_commit = (r_state == S_DATA) && r_write && r_readyout;

    // Little-endian lane merge of HWDATA into the currently stored word.
    always_comb begin
        w_be = 4'b1111;
        case (r_size)
            3'b000:  w_be = 4'b0001 << r_addr[1:0];
            3'b001:  w_be = r_addr[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
        w_wmerge = r_mem[w_wr_idx];
        for (int i = 0; i < 4; i++) begin
            if (w_be[i]) w_wmerge[8*i +: 8] = HWDATA[8*i +: 8];
        end
    end

    // Forward the word being committed on this same edge.
    assign w_rd_word = (w_commit && (w_wr_idx == w_idx)) ? w_wmerge : r_mem[w_idx];

    // Memory is deliberately not reset.
    always_ff @(posedge HCLK) begin
        if (w_commit) r_mem[w_wr_idx] <= w_wmerge;
    end

`ifdef AHB_SLV_WAIT_STATE_EN
    localparam int WCW = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
    logic [WCW-1:0] r_wcnt;
    assign w_waiting = (r_state == S_DATA) && !r_readyout;
`else
    localparam int WAIT_UNUSED = WAIT_CYCLES;
    assign w_waiting = 1'b0;
`endif

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_write    <= 1'b0;
            r_size     <= '0;
            r_rdata    <= '0;
            r_readyout <= 1'b1;
            r_resp     <= 1'b0;
`ifdef AHB_SLV_WAIT_STATE_EN
            r_wcnt     <= '0;
`endif
        end else if (r_state == S_ERR1) begin
            r_state    <= S_ERR2;
            r_readyout <= 1'b1;
            r_resp     <= 1'b1;
        end else if (w_waiting) begin
            // Address/control and read data are held through the wait states.
`ifdef AHB_SLV_WAIT_STATE_EN
            r_wcnt <= r_wcnt - 1'b1;
            if (r_wcnt == WCW'(1)) r_readyout <= 1'b1;
`endif
        end else if (w_accept) begin
            r_addr  <= HADDR[IDX_W+1:0];
            r_write <= HWRITE;
            r_size  <= HSIZE;
            if (w_err) begin
                r_state    <= S_ERR1;
                r_readyout <= 1'b0;
                r_resp     <= 1'b1;
                r_rdata    <= '0;
            end else begin
                r_state <= S_DATA;
                r_resp  <= 1'b0;
                r_rdata <= HWRITE ? '0 : w_rd_word;
`ifdef AHB_SLV_WAIT_STATE_EN
                r_readyout <= (WAIT_CYCLES == 0);
                r_wcnt     <= WCW'(WAIT_CYCLES);
`else
                r_readyout <= 1'b1;
`endif
            end
        end else begin
            r_state    <= S_IDLE;
            r_readyout <= 1'b1;
            r_resp     <= 1'b0;
            r_rdata    <= '0;
        end
    end

    assign HRDATA    = r_rdata;
    assign HREADYOUT = r_readyout;
    assign HRESP     = r_resp;
endmodule
